// File: rtl/bcd_clock_counter.sv
// bcd_clock_counter: hh:mm:ss time-of-day counter that produces a packed
// 24-bit BCD word for the six-digit seven-segment scanner.
//   - A 1 Hz tick is divided down from the system clock (TICK_DIV clocks).
//   - Two active-low pushbuttons, key_mode and key_inc, set the time. Each
//     key is synchronised and debounced on chip.
//   - Optional build macro CLOCK_12H_EN selects a 12-hour clock (12,01..11)
//     and adds a pm output. When the macro is undefined the clock runs
//     00..23 and there is no pm port.

// Key conditioner: a 2-flop synchroniser followed by a stable-level counter.
// A press event is a single-cycle pulse on the accepted high->low transition.
module bcd_clock_key_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // Bring the raw key into the clk domain; reset to the released level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, which keeps the synchroniser a true two-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive clocks the synchronised level differs from the
  // accepted level; accept it on the DEB_CYCLES-th such clock.
  // NOTE: every output of this block is assigned a default first so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    accept  = (sync2_q != level_q) && (cnt_q == CNT_LAST);
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (accept) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accepted level and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Only the falling (press) transition produces an event.
  assign press_o = accept & ~sync2_q;

endmodule

module bcd_clock_counter #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode,
  input  logic        key_inc,
  output logic [23:0] data,
  output logic [1:0]  mode,
  output logic        sec_pulse
`ifdef CLOCK_12H_EN
  ,
  output logic        pm
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SET_H = 2'd1,
    ST_SET_M = 2'd2,
    ST_SET_S = 2'd3
  } state_e;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HOUR_RESET = 8'h12;
`else
  localparam logic [7:0] HOUR_RESET = 8'h00;
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic          sec_pulse_q, sec_pulse_d;
  logic [7:0]    h_q, h_d;
  logic [7:0]    m_q, m_d;
  logic [7:0]    s_q, s_d;
  logic          mode_evt, inc_evt;
`ifdef CLOCK_12H_EN
  logic          pm_q, pm_d;
`endif

  // Two-digit BCD increment wrapping 59 -> 00 (minutes and seconds).
  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v == 8'h59)       return 8'h00;
    if (v[3:0] == 4'h9)   return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  // Two-digit BCD hour increment: 23 -> 00, or 12 -> 01 in 12-hour builds.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
`ifdef CLOCK_12H_EN
    if (v == 8'h12)       return 8'h01;
`else
    if (v == 8'h23)       return 8'h00;
`endif
    if (v[3:0] == 4'h9)   return {v[7:4] + 4'h1, 4'h0};
    return {v[7:4], v[3:0] + 4'h1};
  endfunction

  bcd_clock_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_mode),
    .press_o (mode_evt)
  );

  bcd_clock_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_inc),
    .press_o (inc_evt)
  );

  // 1 s divider: free-runs only in RUN, parked at zero while setting so the
  // first tick after leaving SET_S lands a full TICK_DIV clocks later.
  always_comb begin
    tick_cnt_d = '0;
    tick       = 1'b0;
    if (state_q == ST_RUN) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Mode sequencing: a mode press always wins over a same-cycle inc press.
  always_comb begin
    state_d = state_q;
    if (mode_evt) begin
      case (state_q)
        ST_RUN:   state_d = ST_SET_H;
        ST_SET_H: state_d = ST_SET_M;
        ST_SET_M: state_d = ST_SET_S;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Time update: cascaded carry on a tick, or a single-field increment on an
  // inc press while setting (no carry into neighbouring fields).
  always_comb begin
    h_d         = h_q;
    m_d         = m_q;
    s_d         = s_q;
    sec_pulse_d = tick;
`ifdef CLOCK_12H_EN
    pm_d        = pm_q;
`endif
    if (tick) begin
      s_d = inc_mod60(s_q);
      if (s_q == 8'h59) begin
        m_d = inc_mod60(m_q);
        if (m_q == 8'h59) begin
          h_d = inc_hour(h_q);
`ifdef CLOCK_12H_EN
          if (h_q == 8'h11) pm_d = ~pm_q;
`endif
        end
      end
    end else if (inc_evt && !mode_evt) begin
      case (state_q)
        ST_SET_H: begin
          h_d = inc_hour(h_q);
`ifdef CLOCK_12H_EN
          if (h_q == 8'h11) pm_d = ~pm_q;
`endif
        end
        ST_SET_M: m_d = inc_mod60(m_q);
        ST_SET_S: s_d = inc_mod60(s_q);
        default:  ;
      endcase
    end
  end

  // All architectural state; reset discards any partially set time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      tick_cnt_q  <= '0;
      sec_pulse_q <= 1'b0;
      h_q         <= HOUR_RESET;
      m_q         <= 8'h00;
      s_q         <= 8'h00;
`ifdef CLOCK_12H_EN
      pm_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_pulse_q <= sec_pulse_d;
      h_q         <= h_d;
      m_q         <= m_d;
      s_q         <= s_d;
`ifdef CLOCK_12H_EN
      pm_q        <= pm_d;
`endif
    end
  end

  assign data      = {h_q, m_q, s_q};
  assign mode      = state_q;
  assign sec_pulse = sec_pulse_q;
`ifdef CLOCK_12H_EN
  assign pm        = pm_q;
`endif

endmodule
